// File: rtl/ntt_pkg.sv
// Shared types, Dilithium constants and modular add/sub helpers for the NTT butterfly.
package ntt_pkg;

   parameter int unsigned PKG_W = 23;

   typedef enum logic {
      MODE_CT = 1'b0,
      MODE_GS = 1'b1
   } mode_e;

   localparam logic [22:0] DILITHIUM_Q  = 23'd8380417;
   localparam logic [24:0] DILITHIUM_MU = 25'd8396807;

   // Inputs are assumed < q, so a single conditional correction suffices.
   function automatic logic [PKG_W-1:0] mod_add_f(input logic [PKG_W-1:0] a,
                                                  input logic [PKG_W-1:0] b,
                                                  input logic [PKG_W-1:0] q);
      logic [PKG_W:0] sum;
      sum = {1'b0, a} + {1'b0, b};
      if (sum >= {1'b0, q}) begin
         sum = sum - {1'b0, q};
      end
      return sum[PKG_W-1:0];
   endfunction

   function automatic logic [PKG_W-1:0] mod_sub_f(input logic [PKG_W-1:0] a,
                                                  input logic [PKG_W-1:0] b,
                                                  input logic [PKG_W-1:0] q);
      logic [PKG_W:0] diff;
      diff = {1'b0, a} - {1'b0, b};
      if (diff[PKG_W]) begin
         diff = diff + {1'b0, q};
      end
      return diff[PKG_W-1:0];
   endfunction

endpackage

// File: rtl/ntt_butterfly_pipe_barrett_reduce.sv
// Barrett reduction: registered coarse estimate r < 3q, then two combinational
// conditional subtractions give m < q.
module barrett_reduce
   import ntt_pkg::*;
#(
   parameter int unsigned DATA_W = 23
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  en_i,
   input  logic [2*DATA_W-1:0]   p_i,
   input  logic [DATA_W-1:0]     q_i,
   input  logic [DATA_W+1:0]     mu_i,
   output logic [DATA_W-1:0]     m_o
);

   logic [DATA_W:0]     p_hi;
   logic [2*DATA_W+2:0] pm;
   logic [DATA_W+1:0]   t;
   logic [DATA_W+1:0]   tq;
   logic [DATA_W+1:0]   r_d;
   logic [DATA_W+1:0]   r_q;
   logic [DATA_W+1:0]   q_ext;
   logic [DATA_W+1:0]   m1;
   logic [DATA_W+1:0]   m2;
   logic                unused_bits;

   assign q_ext = {2'b00, q_i};
   assign p_hi  = p_i[2*DATA_W-1:DATA_W-1];
   assign pm    = {{(DATA_W+2){1'b0}}, p_hi} * {{(DATA_W+1){1'b0}}, mu_i};
   assign t     = pm[2*DATA_W+2:DATA_W+1];
   // Only the low DATA_W+2 bits matter since the true remainder is < 3q.
   assign tq    = t * q_ext;
   assign r_d   = p_i[DATA_W+1:0] - tq;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_q <= '0;
      end else if (en_i) begin
         r_q <= r_d;
      end
   end

   always_comb begin
      m1 = r_q;
      if (r_q >= q_ext) begin
         m1 = r_q - q_ext;
      end
      m2 = m1;
      if (m1 >= q_ext) begin
         m2 = m1 - q_ext;
      end
   end

   assign m_o         = m2[DATA_W-1:0];
   assign unused_bits = ^{pm[DATA_W:0], m2[DATA_W+1:DATA_W]};

endmodule

// File: rtl/ntt_butterfly_pipe.sv
// Four-stage CT/GS NTT butterfly with global-stall valid/ready handshake and tag passthrough.
module ntt_butterfly_pipe
   import ntt_pkg::*;
#(
   parameter int unsigned DATA_W = 23,
   parameter int unsigned TAG_W  = 8
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              flush_i,
   input  logic [DATA_W-1:0] q_i,
   input  logic [DATA_W+1:0] mu_i,
   input  logic              in_valid_i,
   output logic              in_ready_o,
   input  logic              mode_i,
   input  logic [DATA_W-1:0] a_i,
   input  logic [DATA_W-1:0] b_i,
   input  logic [DATA_W-1:0] twiddle_i,
   input  logic [TAG_W-1:0]  tag_i,
   output logic              out_valid_o,
   input  logic              out_ready_i,
   output logic [DATA_W-1:0] a_prime_o,
   output logic [DATA_W-1:0] b_prime_o,
   output logic [TAG_W-1:0]  tag_o,
   output logic              busy_o
);

   logic v1_q, v2_q, v3_q, v4_q;
   logic adv;
   logic accept;

   logic [DATA_W-1:0]   s1_d, d1_d;
   logic [DATA_W-1:0]   s1_q, d1_q, w1_q;
   mode_e               mode1_q, mode2_q, mode3_q;
   logic [TAG_W-1:0]    tag1_q, tag2_q, tag3_q;
   logic [2*DATA_W-1:0] p2_d, p2_q;
   logic [DATA_W-1:0]   s2_q, s3_q;
   logic [DATA_W-1:0]   m;
   logic [DATA_W-1:0]   a_prime_d, b_prime_d;

   assign adv         = ~v4_q | out_ready_i;
   assign in_ready_o  = adv;
   assign accept      = in_valid_i & adv;
   assign out_valid_o = v4_q;
   assign busy_o      = v1_q | v2_q | v3_q | v4_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         v1_q <= 1'b0;
         v2_q <= 1'b0;
         v3_q <= 1'b0;
         v4_q <= 1'b0;
      end else if (flush_i) begin
         v1_q <= 1'b0;
         v2_q <= 1'b0;
         v3_q <= 1'b0;
         v4_q <= 1'b0;
      end else if (adv) begin
         v1_q <= accept;
         v2_q <= v1_q;
         v3_q <= v2_q;
         v4_q <= v3_q;
      end
   end

   always_comb begin
      s1_d = a_i;
      d1_d = b_i;
      if (mode_e'(mode_i) == MODE_GS) begin
         s1_d = mod_add_f(a_i, b_i, q_i);
         d1_d = mod_sub_f(a_i, b_i, q_i);
      end
   end

   assign p2_d = {{DATA_W{1'b0}}, d1_q} * {{DATA_W{1'b0}}, w1_q};

   // Stage data needs no valid qualification: bubbles carry don't-care payloads.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         s1_q    <= '0;
         d1_q    <= '0;
         w1_q    <= '0;
         mode1_q <= MODE_CT;
         tag1_q  <= '0;
         p2_q    <= '0;
         s2_q    <= '0;
         mode2_q <= MODE_CT;
         tag2_q  <= '0;
         s3_q    <= '0;
         mode3_q <= MODE_CT;
         tag3_q  <= '0;
      end else if (adv) begin
         s1_q    <= s1_d;
         d1_q    <= d1_d;
         w1_q    <= twiddle_i;
         mode1_q <= mode_e'(mode_i);
         tag1_q  <= tag_i;
         p2_q    <= p2_d;
         s2_q    <= s1_q;
         mode2_q <= mode1_q;
         tag2_q  <= tag1_q;
         s3_q    <= s2_q;
         mode3_q <= mode2_q;
         tag3_q  <= tag2_q;
      end
   end

   barrett_reduce #(
      .DATA_W (DATA_W)
   ) u_barrett (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .en_i   (adv),
      .p_i    (p2_q),
      .q_i    (q_i),
      .mu_i   (mu_i),
      .m_o    (m)
   );

   always_comb begin
      a_prime_d = s3_q;
      b_prime_d = m;
      if (mode3_q == MODE_CT) begin
         a_prime_d = mod_add_f(s3_q, m, q_i);
         b_prime_d = mod_sub_f(s3_q, m, q_i);
      end
   end

   // Output data only updates on a real result so it holds while out_valid_o = 0.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         a_prime_o <= '0;
         b_prime_o <= '0;
         tag_o     <= '0;
      end else if (adv && v3_q && !flush_i) begin
         a_prime_o <= a_prime_d;
         b_prime_o <= b_prime_d;
         tag_o     <= tag3_q;
      end
   end

endmodule

// File: tb/tb_ntt_butterfly_pipe.sv
// Scoreboard bench for ntt_butterfly_pipe: directed vectors plus randomized CT/GS traffic.
module tb_ntt_butterfly_pipe;

   localparam int W  = 23;
   localparam int TW = 8;
   localparam int Q  = 8380417;
   localparam int MU = 8396807;

   logic          clk = 1'b0;
   logic          rst_n, flush, in_valid, in_ready, mode, out_valid, out_ready, busy;
   logic [W-1:0]  q, a, b, w, ap, bp;
   logic [W+1:0]  mu;
   logic [TW-1:0] tag, tag_out;

   typedef struct {
      logic [W-1:0]  a;
      logic [W-1:0]  b;
      logic [TW-1:0] tag;
      bit            lat;
      int            cyc;
   } exp_t;

   exp_t       sb[$];
   int         checks = 0;
   int         errors = 0;
   int         cyc = 0;
   int         rdy_mode = 0;
   int         pk = 0;
   logic [3:0] pat = 4'b1001;

   always #5 clk = ~clk;

   ntt_butterfly_pipe #(
      .DATA_W (W),
      .TAG_W  (TW)
   ) dut (
      .clk_i       (clk),
      .rst_ni      (rst_n),
      .flush_i     (flush),
      .q_i         (q),
      .mu_i        (mu),
      .in_valid_i  (in_valid),
      .in_ready_o  (in_ready),
      .mode_i      (mode),
      .a_i         (a),
      .b_i         (b),
      .twiddle_i   (w),
      .tag_i       (tag),
      .out_valid_o (out_valid),
      .out_ready_i (out_ready),
      .a_prime_o   (ap),
      .b_prime_o   (bp),
      .tag_o       (tag_out),
      .busy_o      (busy)
   );

   task automatic chk(input string nm, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Reference butterfly straight from the modular definitions.
   task automatic ref_bfly(input bit md, input longint av, input longint bv, input longint wv,
                           output longint ra, output longint rb);
      longint mm;
      if (!md) begin
         mm = (bv * wv) % Q;
         ra = (av + mm) % Q;
         rb = (av - mm + Q) % Q;
      end else begin
         ra = (av + bv) % Q;
         rb = (((av - bv + Q) % Q) * wv) % Q;
      end
   endtask

   task automatic send(input bit md, input logic [W-1:0] av, input logic [W-1:0] bv,
                       input logic [W-1:0] wv, input logic [TW-1:0] tg,
                       input logic [W-1:0] ea, input logic [W-1:0] eb, input bit lat);
      exp_t e;
      bit   done = 0;
      mode     = md;
      a        = av;
      b        = bv;
      w        = wv;
      tag      = tg;
      in_valid = 1'b1;
      for (int i = 0; i < 200 && !done; i++) begin
         @(negedge clk);
         if (in_ready) begin
            e.a   = ea;
            e.b   = eb;
            e.tag = tg;
            e.lat = lat;
            e.cyc = cyc + 1;
            sb.push_back(e);
            done  = 1;
         end
         @(posedge clk);
         #1;
      end
      in_valid = 1'b0;
      if (!done) begin
         checks++;
         errors++;
         $display("FAIL send_timeout: tag %0d never accepted, expected acceptance", tg);
      end
   endtask

   task automatic send_rand(input logic [TW-1:0] tg);
      bit     md;
      longint av, bv, wv, ra, rb;
      md = 1'($urandom_range(0, 1));
      av = longint'($urandom_range(0, Q - 1));
      bv = longint'($urandom_range(0, Q - 1));
      wv = longint'($urandom_range(0, Q - 1));
      ref_bfly(md, av, bv, wv, ra, rb);
      send(md, W'(av), W'(bv), W'(wv), tg, W'(ra), W'(rb), 1'b0);
   endtask

   task automatic drain();
      for (int i = 0; i < 400 && sb.size() != 0; i++) @(posedge clk);
      if (sb.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL drain_timeout: %0d results outstanding, expected 0", sb.size());
      end
      repeat (2) @(posedge clk);
      #1;
   endtask

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   initial forever begin
      @(posedge clk);
      #1;
      if (rdy_mode == 1) begin
         out_ready = pat[pk % 4];
         pk++;
      end else if (rdy_mode == 2) begin
         out_ready = 1'($urandom_range(0, 1));
      end
   end

   // Monitor: sample mid-cycle, pop on every output handshake.
   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clk);
         if (rst_n === 1'b1) begin
            chk("in_ready_rule", in_ready, (!out_valid || out_ready) ? 1 : 0);
            if (out_valid && out_ready) begin
               if (sb.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL unexpected_out: got tag %0d a'=%0d, expected no result",
                           tag_out, ap);
               end else begin
                  e = sb.pop_front();
                  chk("a_prime", ap, e.a);
                  chk("b_prime", bp, e.b);
                  chk("tag", tag_out, e.tag);
                  if (e.lat) chk("latency", cyc, e.cyc + 3);
               end
            end
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n     = 1'b0;
      flush     = 1'b0;
      in_valid  = 1'b0;
      mode      = 1'b0;
      a         = '0;
      b         = '0;
      w         = '0;
      tag       = '0;
      out_ready = 1'b1;
      q         = W'(Q);
      mu        = (W + 2)'(MU);
      #12;
      chk("rst_out_valid", out_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_a_prime", ap, 0);
      chk("rst_b_prime", bp, 0);
      chk("rst_tag", tag_out, 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      chk("rst_in_ready", in_ready, 1);

      // Directed vectors
      send(1'b0, 23'd1, 23'd2, 23'd3, 8'h11, 23'd7, 23'd8380412, 1'b1);
      drain();
      send(1'b1, 23'd10, 23'd3, 23'd2, 8'h22, 23'd13, 23'd14, 1'b1);
      drain();
      chk("hold_a_prime", ap, 13);
      chk("hold_b_prime", bp, 14);
      chk("idle_out_valid", out_valid, 0);
      chk("idle_busy", busy, 0);
      send(1'b0, 23'd8380416, 23'd1, 23'd1, 8'h03, 23'd0, 23'd8380415, 1'b1);
      send(1'b0, 23'd0, 23'd8380416, 23'd8380416, 8'h04, 23'd1, 23'd8380416, 1'b0);
      send(1'b1, 23'd0, 23'd1, 23'd8380416, 8'h05, 23'd1, 23'd1, 1'b0);
      drain();

      // Backpressure with out_ready pattern 1,0,0,1
      pk       = 0;
      rdy_mode = 1;
      for (int t = 0; t < 16; t++) send_rand(TW'(t));
      drain();
      rdy_mode  = 0;
      out_ready = 1'b1;

      // Asynchronous reset mid-stream
      for (int t = 0; t < 3; t++) send_rand(TW'(8'h30 + t));
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_out_valid", out_valid, 0);
      chk("arst_busy", busy, 0);
      sb.delete();
      @(posedge clk);
      #2;
      rst_n = 1'b1;
      repeat (8) @(posedge clk);
      #1;
      chk("post_rst_busy", busy, 0);
      send(1'b0, 23'd1, 23'd2, 23'd3, 8'h41, 23'd7, 23'd8380412, 1'b1);
      drain();

      // Synchronous flush mid-stream; the transaction presented alongside is dropped
      for (int t = 0; t < 3; t++) send_rand(TW'(8'h50 + t));
      flush    = 1'b1;
      in_valid = 1'b1;
      tag      = 8'h5f;
      sb.delete();
      @(posedge clk);
      #1;
      flush    = 1'b0;
      in_valid = 1'b0;
      chk("flush_out_valid", out_valid, 0);
      chk("flush_busy", busy, 0);
      repeat (6) @(posedge clk);
      #1;
      for (int t = 0; t < 4; t++) send_rand(TW'(8'h60 + t));
      drain();
      chk("post_flush_busy", busy, 0);

      // Random traffic with random gaps and random backpressure
      rdy_mode = 2;
      for (int t = 0; t < 40; t++) begin
         if ($urandom_range(0, 3) == 0) begin
            @(posedge clk);
            #1;
         end
         send_rand(TW'(8'h80 + t));
      end
      drain();
      rdy_mode  = 0;
      out_ready = 1'b1;
      repeat (2) @(posedge clk);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/ntt_butterfly_pipe.md
Name: ntt_butterfly_pipe

Overview:
- Parametrised, pipelined successor to the single-cycle combinational butterfly.
- Computes one Cooley-Tukey (CT) or Gentleman-Sande (GS) butterfly per clock. Mode is selected per transaction.
- Fixed 4-cycle latency, valid/ready handshake on both sides, transaction tag passthrough.
- Sits between the NTT/INTT controller's coefficient-memory read port and its write-back path.

Parameters:
- DATA_W, 23, coefficient and modulus width (q < 2^DATA_W).
- TAG_W, 8, width of the opaque tag carried alongside each transaction.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_ni  in  1  asynchronous reset, active low.
- flush_i  in  1  synchronous pipeline clear.
- q_i  in  DATA_W  modulus; quasi-static.
- mu_i  in  DATA_W+2  Barrett constant floor(2^(2*DATA_W)/q); quasi-static.
- in_valid_i  in  1  input transaction valid.
- in_ready_o  out  1  pipeline can accept a transaction this cycle.
- mode_i  in  1  0 = CT, 1 = GS.
- a_i  in  DATA_W  operand a, < q.
- b_i  in  DATA_W  operand b, < q.
- twiddle_i  in  DATA_W  twiddle w, < q.
- tag_i  in  TAG_W  transaction tag.
- out_valid_o  out  1  result valid.
- out_ready_i  in  1  downstream accepts the result.
- a_prime_o  out  DATA_W  result a'.
- b_prime_o  out  DATA_W  result b'.
- tag_o  out  TAG_W  tag of the result.
- busy_o  out  1  at least one stage holds a valid transaction.

Behaviour:
- Reset (rst_ni = 0, asynchronous): all stage valid bits clear. out_valid_o = 0, busy_o = 0, a_prime_o = 0, b_prime_o = 0, tag_o = 0. in_ready_o = 1 once reset is released. Reset mid-operation discards all in-flight work.
- Advance: adv = ~out_valid_o | out_ready_i. When adv = 1, all four stages shift together. When adv = 0, every stage holds (global stall).
- Input handshake: in_ready_o = adv. A transaction is accepted when in_valid_i & in_ready_o. On a cycle with adv = 1 and no accepted transaction, a bubble (valid = 0) enters S1.
- Latency: a transaction accepted at edge N appears on the outputs after edge N+3 (4 register stages) when there is no stall. Throughput is 1 per cycle.
- Stage S1 (pre-add):
  - GS: s = (a+b) mod q, d = (a-b) mod q.
  - CT: s = a, d = b.
  - Register s, d, w, mode, tag.
- Stage S2: register the product p = d*w (2*DATA_W bits).
- Stage S3 (Barrett):
  - t = ((p >> (DATA_W-1)) * mu) >> (DATA_W+1).
  - r = p - t*q, computed at DATA_W+2 bits.
  - Guaranteed r < 3q. Register r.
- Stage S4 (correct and combine):
  - m = r, with q subtracted conditionally twice, giving m < q.
  - CT: a' = (s+m) mod q, b' = (s-m) mod q.
  - GS: a' = s, b' = m.
  - Register the outputs.
- Modular add/sub: compute at DATA_W+1 bits; subtract q when the sum is >= q; add q when the difference is negative.
- mode and tag travel with their own transaction, so mixed-mode streams are legal.
- q_i and mu_i are sampled combinationally in every stage. They may change only while busy_o = 0; otherwise the results are undefined.
- Operands >= q: the results are undefined. They are not checked.
- flush_i = 1 clears all valid bits at the next edge, which gives out_valid_o = 0 and busy_o = 0. A transaction presented in the same cycle is dropped. flush_i has priority over adv.
- Output data registers hold their last value while out_valid_o = 0.
- busy_o = OR of all stage valid bits.

Decomposition:
- Package ntt_pkg holds:
  - typedef mode_e {MODE_CT = 0, MODE_GS = 1}.
  - Constants DILITHIUM_Q = 23'd8380417 and DILITHIUM_MU = 25'd8396807.
  - Pure functions mod_add_f and mod_sub_f, parametrised by width via a package parameter.
- One sub-module, barrett_reduce: a registered S3 plus a combinational correction that returns m. It takes p, q and mu and has an enable input tied to adv.
- Everything else stays inline.

Test Plan:
- Test 1, CT basic. q = 8380417, mu = 8396807; CT with a = 1, b = 2, w = 3, tag = 0x11.
  - Required: 4 cycles later a' = 7, b' = 8380412, tag_o = 0x11.
- Test 2, GS basic. GS with a = 10, b = 3, w = 2.
  - Required: a' = 13, b' = 14.
- Test 3, wrap. CT with a = 8380416, b = 1, w = 1.
  - Required: a' = 0, b' = 8380415.
- Test 4, max product. CT with a = 0, b = w = 8380416 (p = (q-1)^2).
  - Required: a' = 1, b' = 8380416.
  - Then GS with a = 0, b = 1, w = 8380416.
  - Required: a' = 1, b' = 1.
- Test 5, backpressure. Stream 16 back-to-back mixed CT/GS transactions with tags 0..15 while out_ready_i follows the pattern 1,0,0,1 repeating.
  - Required: all 16 results arrive in order, tags match, and each result matches the reference model.
  - Required: in_ready_o = 0 exactly when out_valid_o = 1 and out_ready_i = 0.
- Test 6, reset and flush.
  - Load 3 transactions, then assert rst_ni = 0 for one cycle mid-stream. Required: out_valid_o and busy_o drop immediately (asynchronously) and no stale result ever appears.
  - Repeat with flush_i instead. Required: the same clearing at the next edge, after which new transactions complete normally.
